alu_serial_seq: RTL

Bit-serial sequencer that executes 16-bit ALU operations on a single `Alu1bit` slice, one bit per clock, LSB first. It drives the slice's `a`, `b`, `cin`, `binvert`, `less` and `op` inputs, and captures `rez` and `cout` into a result shift register and a carry register. It gives the area-minimal CPU build a full-width ALU behind a start/done handshake.

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_serial_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: func codes, slice op codes,
// FSM states and the func-to-slice-op mapping.
package alu_seq_pkg;

   localparam logic [2:0] FUNC_AND = 3'b000;
   localparam logic [2:0] FUNC_OR  = 3'b001;
   localparam logic [2:0] FUNC_XOR = 3'b010;
   localparam logic [2:0] FUNC_ADD = 3'b011;
   localparam logic [2:0] FUNC_SUB = 3'b100;
   localparam logic [2:0] FUNC_SLT = 3'b101;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_LESS = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_SLT_RUN,
      ST_DONE
   } state_t;

   function automatic logic [2:0] func_to_op(input logic [2:0] func);
      logic [2:0] op;
      case (func)
         FUNC_AND:                     op = OP_AND;
         FUNC_OR:                      op = OP_OR;
         FUNC_XOR:                     op = OP_XOR;
         FUNC_ADD, FUNC_SUB, FUNC_SLT: op = OP_ADD;
         default:                      op = OP_AND;
      endcase
      return op;
   endfunction

   function automatic logic func_legal(input logic [2:0] func);
      return (func <= FUNC_SLT);
   endfunction

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first.
// Define ALU_SEQ_FLAGS_EN to build the carry/overflow/zero flag registers.
module alu_serial_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_func,
   input  logic [WIDTH-1:0] i_a_in,
   input  logic [WIDTH-1:0] i_b_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow,
   output logic             o_zero,
   output logic             o_alu_a,
   output logic             o_alu_b,
   output logic             o_alu_cin,
   output logic             o_alu_binvert,
   output logic             o_alu_less,
   output logic [2:0]       o_alu_op,
   input  logic             i_alu_rez,
   input  logic             i_alu_cout
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   state_t           r_state;
   logic [2:0]       r_func;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [IW-1:0]    r_idx;
   logic             r_cin;
   logic             r_binvert;
   logic             r_less;
   logic [2:0]       r_op;
   logic             r_busy;
   logic             r_done;

   logic w_last;
   logic w_arith;
   logic w_ovf;

   assign w_last  = (r_idx == LAST);
   assign w_arith = (r_func == FUNC_ADD) || (r_func == FUNC_SUB) || (r_func == FUNC_SLT);
   // r_cin holds the carry out of the previous bit, i.e. the carry into the current one
   assign w_ovf   = r_cin ^ i_alu_cout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_func    <= FUNC_AND;
         r_a       <= '0;
         r_b       <= '0;
         r_result  <= '0;
         r_idx     <= '0;
         r_cin     <= 1'b0;
         r_binvert <= 1'b0;
         r_less    <= 1'b0;
         r_op      <= OP_AND;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_func   <= i_func;
                  r_idx    <= '0;
                  r_result <= '0;
                  if (func_legal(i_func)) begin
                     r_a       <= i_a_in;
                     r_b       <= i_b_in;
                     r_op      <= func_to_op(i_func);
                     r_binvert <= (i_func == FUNC_SUB) || (i_func == FUNC_SLT);
                     r_cin     <= (i_func == FUNC_SUB) || (i_func == FUNC_SLT);
                     r_busy    <= 1'b1;
                     r_state   <= ST_RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               r_result[r_idx] <= i_alu_rez;
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_cin <= w_arith & i_alu_cout;
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_idx     <= '0;
                  r_cin     <= 1'b0;
                  r_binvert <= 1'b0;
                  if (r_func == FUNC_SLT) begin
                     r_op    <= OP_LESS;
                     r_less  <= i_alu_rez ^ w_ovf;
                     r_state <= ST_SLT_RUN;
                  end else begin
                     r_op    <= OP_AND;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_SLT_RUN: begin
               r_result[r_idx] <= i_alu_rez;
               r_less <= 1'b0;
               r_idx  <= r_idx + 1'b1;
               if (w_last) begin
                  r_idx   <= '0;
                  r_op    <= OP_AND;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_result      = r_result;
   assign o_alu_a       = r_a[0];
   assign o_alu_b       = r_b[0];
   assign o_alu_cin     = r_cin;
   assign o_alu_binvert = r_binvert;
   assign o_alu_less    = r_less;
   assign o_alu_op      = r_op;

`ifdef ALU_SEQ_FLAGS_EN
   logic             r_carry;
   logic             r_overflow;
   logic             r_zero;
   logic [WIDTH-1:0] w_res_nx;
   logic             w_to_done;

   always_comb begin
      w_res_nx        = r_result;
      w_res_nx[r_idx] = i_alu_rez;
   end

   assign w_to_done = w_last && (((r_state == ST_RUN) && (r_func != FUNC_SLT)) ||
                                 (r_state == ST_SLT_RUN));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else if ((r_state == ST_IDLE) && i_start) begin
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         if ((r_state == ST_RUN) && w_last) begin
            r_carry    <= w_arith & i_alu_cout;
            r_overflow <= w_arith & w_ovf;
         end
         if (w_to_done)
            r_zero <= (w_res_nx == '0);
      end
   end

   assign o_carry    = r_carry;
   assign o_overflow = r_overflow;
   assign o_zero     = r_zero;
`else
   assign o_carry    = 1'b0;
   assign o_overflow = 1'b0;
   assign o_zero     = 1'b0;
`endif

endmodule
